// File: rtl/nios2_cordic_cpu_mult_seq.sv
// Sequential signed/unsigned multiplier: one SLICE_W x DATA_W partial product per cycle, then a sign-correction step.
// Latency NSLICE+1 edges after the start edge; start is ignored while busy, flush aborts without a done pulse.
module nios2_cordic_cpu_mult_seq #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              src1_signed,
    input  logic              src2_signed,
    input  logic              hi_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int SHW    = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, ACCUM, CORRECT} state_t;

    state_t              state, state_nxt;
    logic [KW-1:0]       k;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] pp;
    logic [DATA_W-1:0]   a, b;
    logic                a_sgn, b_sgn, hsel;
    logic [SLICE_W-1:0]  slice;
    logic [SHW-1:0]      sh;
    logic [DATA_W-1:0]   hi_fix;
    logic                accept, last;

    assign accept = (state == IDLE) && start && !flush;
    assign last   = (k == KW'(NSLICE - 1));
    assign busy   = (state != IDLE);

    always_comb begin
        slice = b[k*SLICE_W +: SLICE_W];
        sh    = SHW'(k) * SHW'(SLICE_W);
        pp    = ({{DATA_W{1'b0}}, a} * {{(2*DATA_W-SLICE_W){1'b0}}, slice}) << sh;
    end

    // The unsigned product over-counts by 2^DATA_W * (other operand) per negative signed operand.
    assign hi_fix = acc[2*DATA_W-1:DATA_W]
                  - ((a_sgn && a[DATA_W-1]) ? b : '0)
                  - ((b_sgn && b[DATA_W-1]) ? a : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCUM;
            ACCUM:   if (flush) state_nxt = IDLE;
                     else if (last) state_nxt = CORRECT;
            CORRECT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            k      <= '0;
            done   <= 1'b0;
            result <= '0;
            a      <= '0;
            b      <= '0;
            a_sgn  <= 1'b0;
            b_sgn  <= 1'b0;
            hsel   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    a     <= src1;
                    b     <= src2;
                    a_sgn <= src1_signed;
                    b_sgn <= src2_signed;
                    hsel  <= hi_sel;
                    acc   <= '0;
                    k     <= '0;
                end
                ACCUM: if (!flush) begin
                    acc <= acc + pp;
                    k   <= k + KW'(1);
                end
                CORRECT: if (!flush) begin
                    acc    <= {hi_fix, acc[DATA_W-1:0]};
                    result <= hsel ? hi_fix : acc[DATA_W-1:0];
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
